// File: rtl/vp_arbiter.sv
// vp_arbiter: round-robin arbiter/sequencer sharing one vector processor
// among NUM_REQ shader pipeline requesters. One transaction at a time:
// capture operands, pulse vp_start, wait for the result under a watchdog,
// and return a one-cycle response to the owning requester.
module vp_arbiter #(
   parameter int unsigned NUM_REQ        = 4,
   parameter int unsigned DATA_WIDTH     = 16,
   parameter int unsigned VECTOR_WIDTH   = 4,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic [NUM_REQ-1:0]                        req_valid,
   input  logic [NUM_REQ*4-1:0]                      req_op,
   input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_a,
   input  logic [NUM_REQ*VECTOR_WIDTH*DATA_WIDTH-1:0] req_vec_b,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]             req_scalar,
   output logic [NUM_REQ-1:0]                        req_ready,
   output logic [NUM_REQ-1:0]                        rsp_valid,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        rsp_data,
   output logic                                      rsp_timeout,
   output logic                                      vp_start,
   output logic [3:0]                                vp_operation,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_a,
   output logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_vec_b,
   output logic [DATA_WIDTH-1:0]                     vp_scalar,
   input  logic                                      vp_busy,
   input  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]        vp_result,
   input  logic                                      vp_result_valid,
   output logic [7:0]                                timeout_count,
   output logic                                      arb_busy
);

   localparam int unsigned VEC_W = VECTOR_WIDTH * DATA_WIDTH;
   localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned CW    = IDX_W + 1;
   localparam int unsigned WD_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_ISSUE   = 2'd1;
   localparam logic [1:0] S_WAIT    = 2'd2;
   localparam logic [1:0] S_RESPOND = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [IDX_W-1:0]      ptr_q, ptr_d;
   logic [IDX_W-1:0]      owner_q, owner_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
   logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
   logic [VEC_W-1:0]      rsp_data_q, rsp_data_d;
   logic                  rsp_timeout_q, rsp_timeout_d;
   logic                  vp_start_q, vp_start_d;
   logic [3:0]            vp_operation_q, vp_operation_d;
   logic [VEC_W-1:0]      vp_vec_a_q, vp_vec_a_d;
   logic [VEC_W-1:0]      vp_vec_b_q, vp_vec_b_d;
   logic [DATA_WIDTH-1:0] vp_scalar_q, vp_scalar_d;
   logic [7:0]            timeout_count_q, timeout_count_d;
   logic                  arb_busy_q, arb_busy_d;

   logic                  grant_found;
   logic [IDX_W-1:0]      grant_idx;
   logic [CW-1:0]         cand_sum;
   logic [IDX_W-1:0]      cand_idx;
   logic [3:0]            sel_op;
   logic [VEC_W-1:0]      sel_vec_a;
   logic [VEC_W-1:0]      sel_vec_b;
   logic [DATA_WIDTH-1:0] sel_scalar;

   // Round-robin search: first valid requester at or after the pointer, with wrap
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_sum    = '0;
      cand_idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand_sum = {1'b0, ptr_q} + CW'(i);
         if (cand_sum >= CW'(NUM_REQ)) begin
            cand_sum = cand_sum - CW'(NUM_REQ);
         end
         cand_idx = cand_sum[IDX_W-1:0];
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Operand mux for the candidate winner
   always_comb begin
      sel_op     = '0;
      sel_vec_a  = '0;
      sel_vec_b  = '0;
      sel_scalar = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (grant_idx == IDX_W'(i)) begin
            sel_op     = req_op[i*4 +: 4];
            sel_vec_a  = req_vec_a[i*VEC_W +: VEC_W];
            sel_vec_b  = req_vec_b[i*VEC_W +: VEC_W];
            sel_scalar = req_scalar[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Next-state logic; every output is computed one cycle ahead so it is registered
   always_comb begin
      state_d         = state_q;
      ptr_d           = ptr_q;
      owner_d         = owner_q;
      wdog_d          = wdog_q;
      req_ready_d     = '0;
      rsp_valid_d     = '0;
      rsp_data_d      = rsp_data_q;
      rsp_timeout_d   = rsp_timeout_q;
      vp_start_d      = 1'b0;
      vp_operation_d  = vp_operation_q;
      vp_vec_a_d      = vp_vec_a_q;
      vp_vec_b_d      = vp_vec_b_q;
      vp_scalar_d     = vp_scalar_q;
      timeout_count_d = timeout_count_q;
      case (state_q)
         S_IDLE: begin
            if (grant_found && !vp_busy) begin
               owner_d                = grant_idx;
               vp_operation_d         = sel_op;
               vp_vec_a_d             = sel_vec_a;
               vp_vec_b_d             = sel_vec_b;
               vp_scalar_d            = sel_scalar;
               vp_start_d             = 1'b1;
               req_ready_d[grant_idx] = 1'b1;
               state_d                = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (owner_q == IDX_W'(NUM_REQ - 1)) begin
               ptr_d = '0;
            end else begin
               ptr_d = owner_q + IDX_W'(1);
            end
            wdog_d  = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // A result on the last watchdog cycle takes priority over the timeout
            if (vp_result_valid) begin
               rsp_data_d           = vp_result;
               rsp_timeout_d        = 1'b0;
               rsp_valid_d[owner_q] = 1'b1;
               state_d              = S_RESPOND;
            end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
               rsp_data_d           = '0;
               rsp_timeout_d        = 1'b1;
               rsp_valid_d[owner_q] = 1'b1;
               if (timeout_count_q != 8'hFF) begin
                  timeout_count_d = timeout_count_q + 8'd1;
               end
               state_d = S_RESPOND;
            end else begin
               wdog_d = wdog_q + WD_W'(1);
            end
         end
         S_RESPOND: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      arb_busy_d = (state_d != S_IDLE);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= S_IDLE;
         ptr_q           <= '0;
         owner_q         <= '0;
         wdog_q          <= '0;
         req_ready_q     <= '0;
         rsp_valid_q     <= '0;
         rsp_data_q      <= '0;
         rsp_timeout_q   <= 1'b0;
         vp_start_q      <= 1'b0;
         vp_operation_q  <= '0;
         vp_vec_a_q      <= '0;
         vp_vec_b_q      <= '0;
         vp_scalar_q     <= '0;
         timeout_count_q <= '0;
         arb_busy_q      <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         owner_q         <= owner_d;
         wdog_q          <= wdog_d;
         req_ready_q     <= req_ready_d;
         rsp_valid_q     <= rsp_valid_d;
         rsp_data_q      <= rsp_data_d;
         rsp_timeout_q   <= rsp_timeout_d;
         vp_start_q      <= vp_start_d;
         vp_operation_q  <= vp_operation_d;
         vp_vec_a_q      <= vp_vec_a_d;
         vp_vec_b_q      <= vp_vec_b_d;
         vp_scalar_q     <= vp_scalar_d;
         timeout_count_q <= timeout_count_d;
         arb_busy_q      <= arb_busy_d;
      end
   end

   assign req_ready     = req_ready_q;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_timeout   = rsp_timeout_q;
   assign vp_start      = vp_start_q;
   assign vp_operation  = vp_operation_q;
   assign vp_vec_a      = vp_vec_a_q;
   assign vp_vec_b      = vp_vec_b_q;
   assign vp_scalar     = vp_scalar_q;
   assign timeout_count = timeout_count_q;
   assign arb_busy      = arb_busy_q;

endmodule

// File: tb/tb_vp_arbiter.sv
// tb_vp_arbiter: directed self-checking bench for vp_arbiter.
module tb_vp_arbiter;

   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 16;
   localparam int unsigned VW  = 4;
   localparam int unsigned TO  = 64;
   localparam int unsigned VEC = VW * DW;

   logic             clk = 1'b0;
   logic             rst;
   logic [N-1:0]     req_valid;
   logic [N*4-1:0]   req_op;
   logic [N*VEC-1:0] req_vec_a;
   logic [N*VEC-1:0] req_vec_b;
   logic [N*DW-1:0]  req_scalar;
   logic [N-1:0]     req_ready;
   logic [N-1:0]     rsp_valid;
   logic [VEC-1:0]   rsp_data;
   logic             rsp_timeout;
   logic             vp_start;
   logic [3:0]       vp_operation;
   logic [VEC-1:0]   vp_vec_a;
   logic [VEC-1:0]   vp_vec_b;
   logic [DW-1:0]    vp_scalar;
   logic             vp_busy;
   logic [VEC-1:0]   vp_result;
   logic             vp_result_valid;
   logic [7:0]       timeout_count;
   logic             arb_busy;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   logic [3:0]  op_tab [N] = '{4'h1, 4'h7, 4'h4, 4'hB};
   logic [15:0] sc_tab [N] = '{16'h0100, 16'hFF00, 16'h0080, 16'h0233};

   vp_arbiter #(
      .NUM_REQ        (N),
      .DATA_WIDTH     (DW),
      .VECTOR_WIDTH   (VW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_op          (req_op),
      .req_vec_a       (req_vec_a),
      .req_vec_b       (req_vec_b),
      .req_scalar      (req_scalar),
      .req_ready       (req_ready),
      .rsp_valid       (rsp_valid),
      .rsp_data        (rsp_data),
      .rsp_timeout     (rsp_timeout),
      .vp_start        (vp_start),
      .vp_operation    (vp_operation),
      .vp_vec_a        (vp_vec_a),
      .vp_vec_b        (vp_vec_b),
      .vp_scalar       (vp_scalar),
      .vp_busy         (vp_busy),
      .vp_result       (vp_result),
      .vp_result_valid (vp_result_valid),
      .timeout_count   (timeout_count),
      .arb_busy        (arb_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [63:0] vec_a_of(input int unsigned i);
      return {4{sc_tab[i]}} ^ 64'h0123_4567_89AB_CDEF;
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"},   req_ready, 0);
      check({tag, "_rspv"},    rsp_valid, 0);
      check({tag, "_rspd"},    rsp_data, 0);
      check({tag, "_rspto"},   rsp_timeout, 0);
      check({tag, "_start"},   vp_start, 0);
      check({tag, "_op"},      vp_operation, 0);
      check({tag, "_veca"},    vp_vec_a, 0);
      check({tag, "_vecb"},    vp_vec_b, 0);
      check({tag, "_scalar"},  vp_scalar, 0);
      check({tag, "_tocount"}, timeout_count, 0);
      check({tag, "_busy"},    arb_busy, 0);
   endtask

   initial begin
      int unsigned e;
      logic [63:0] res;

      rst             = 1'b1;
      req_valid       = '0;
      req_op          = '0;
      req_vec_a       = '0;
      req_vec_b       = '0;
      req_scalar      = '0;
      vp_busy         = 1'b0;
      vp_result       = '0;
      vp_result_valid = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         req_op[i*4 +: 4]       = op_tab[i];
         req_scalar[i*DW +: DW] = sc_tab[i];
         req_vec_a[i*VEC +: VEC] = vec_a_of(i);
         req_vec_b[i*VEC +: VEC] = ~vec_a_of(i);
      end

      // reset state
      tick();
      tick();
      check_all_zero("rst");
      rst = 1'b0;
      tick();

      // single request from requester 2
      req_valid = 4'b0100;
      tick();
      check("single_ready",  req_ready, 4'b0100);
      check("single_start",  vp_start, 1);
      check("single_scalar", vp_scalar, 16'h0080);
      check("single_op",     vp_operation, 4'h4);
      check("single_veca",   vp_vec_a, vec_a_of(2));
      check("single_vecb",   vp_vec_b, ~vec_a_of(2));
      check("single_busy",   arb_busy, 1);
      req_valid = '0;
      tick();
      check("single_start_pulse", {vp_start, req_ready}, 0);
      vp_result       = 64'h7F80_0000_0000_7F80;
      vp_result_valid = 1'b1;
      tick();
      vp_result_valid = 1'b0;
      check("single_rspv",  rsp_valid, 4'b0100);
      check("single_rspd",  rsp_data, 64'h7F80_0000_0000_7F80);
      check("single_rspto", rsp_timeout, 0);
      tick();
      check("single_rspv_pulse", rsp_valid, 0);
      check("single_idle",       arb_busy, 0);
      check("single_rspd_hold",  rsp_data, 64'h7F80_0000_0000_7F80);

      // round robin from a fresh pointer
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         e   = k % 4;
         res = {16'(k + 1), 16'h00AA, 16'h5500, 16'(k * 3)};
         tick();
         check("rr_ready",  req_ready, 4'b0001 << e);
         check("rr_start",  vp_start, 1);
         check("rr_op",     vp_operation, op_tab[e]);
         check("rr_scalar", vp_scalar, sc_tab[e]);
         tick();
         tick();
         vp_result       = res;
         vp_result_valid = 1'b1;
         tick();
         vp_result_valid = 1'b0;
         check("rr_rspv", rsp_valid, 4'b0001 << e);
         check("rr_rspd", rsp_data, res);
         tick();
         check("rr_gap", {rsp_valid, req_ready}, 0);
      end
      req_valid = '0;

      // vp_busy gating
      vp_busy   = 1'b1;
      req_valid = 4'b0010;
      for (int c = 0; c < 10; c++) begin
         tick();
         check("busy_gate", {req_ready, vp_start, arb_busy}, 0);
      end
      vp_busy = 1'b0;
      tick();
      check("busy_release_ready", req_ready, 4'b0010);
      check("busy_release_start", vp_start, 1);
      req_valid = '0;

      // watchdog timeout
      repeat (TO) tick();
      check("to_early", rsp_valid, 0);
      tick();
      check("to_rspv",  rsp_valid, 4'b0010);
      check("to_rspd",  rsp_data, 0);
      check("to_rspto", rsp_timeout, 1);
      check("to_count", timeout_count, 1);
      tick();

      // result on the final watchdog cycle wins
      req_valid = 4'b1000;
      tick();
      check("last_ready", req_ready, 4'b1000);
      req_valid = '0;
      repeat (TO) tick();
      check("last_early", rsp_valid, 0);
      vp_result       = 64'hCAFE_0123_4567_BEEF;
      vp_result_valid = 1'b1;
      tick();
      vp_result_valid = 1'b0;
      check("last_rspv",  rsp_valid, 4'b1000);
      check("last_rspto", rsp_timeout, 0);
      check("last_rspd",  rsp_data, 64'hCAFE_0123_4567_BEEF);
      check("last_count", timeout_count, 1);
      tick();

      // stray result while idle
      vp_result       = 64'h1111_2222_3333_4444;
      vp_result_valid = 1'b1;
      tick();
      vp_result_valid = 1'b0;
      check("stray_rspv", rsp_valid, 0);
      check("stray_busy", arb_busy, 0);
      tick();
      check("stray_rspv2", rsp_valid, 0);
      check("stray_hold",  rsp_data, 64'hCAFE_0123_4567_BEEF);

      // asynchronous reset in WAIT
      req_valid = 4'b0100;
      tick();
      check("rw_ready", req_ready, 4'b0100);
      req_valid = '0;
      tick();
      tick();
      check("rw_in_wait", arb_busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("rw");
      #1;
      rst = 1'b0;
      tick();
      tick();
      check("rw_no_rsp", {rsp_valid, arb_busy}, 0);
      req_valid = 4'b1101;
      tick();
      check("rw_ptr0_ready", req_ready, 4'b0001);
      check("rw_ptr0_op",    vp_operation, op_tab[0]);
      req_valid = '0;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/vp_arbiter.md
Name: vp_arbiter

Overview:
Round-robin arbiter and sequencer that shares one vector processor among NUM_REQ shader pipeline requesters. It accepts operand bundles over a valid/ready handshake and issues each one as a single vp_start pulse. It waits for the result, with a watchdog timeout, and returns the result to the owning requester as a one-cycle response. It sits between the shader pipelines and the vector processor.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 16, fixed-point component width (8.8)
VECTOR_WIDTH, 4, components per vector
TIMEOUT_CYCLES, 64, maximum WAIT cycles before a forced response (>=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester request, level; held until req_ready
req_op  in  NUM_REQ*4  operation code, requester i at [4i+3:4i]
req_vec_a  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand A, slice i
req_vec_b  in  NUM_REQ*VECTOR_WIDTH*DATA_WIDTH  operand B, slice i
req_scalar  in  NUM_REQ*DATA_WIDTH  scalar operand, slice i
req_ready  out  NUM_REQ  one-hot capture pulse
rsp_valid  out  NUM_REQ  one-hot response pulse
rsp_data  out  VECTOR_WIDTH*DATA_WIDTH  result for the pulsed requester
rsp_timeout  out  1  qualifies rsp_valid: response was forced by the watchdog
vp_start  out  1  one-cycle issue pulse
vp_operation  out  4  latched op
vp_vec_a  out  VECTOR_WIDTH*DATA_WIDTH  latched operand A
vp_vec_b  out  VECTOR_WIDTH*DATA_WIDTH  latched operand B
vp_scalar  out  DATA_WIDTH  latched scalar
vp_busy  in  1  vector processor busy
vp_result  in  VECTOR_WIDTH*DATA_WIDTH  vector processor result
vp_result_valid  in  1  result strobe
timeout_count  out  8  saturating count of timeouts
arb_busy  out  1  high whenever state != IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0. State = IDLE. Round-robin pointer = 0. Watchdog counter = 0. timeout_count = 0.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If any req_valid is high and vp_busy = 0, select the first requester at or after the pointer, searching upward with wrap.
  - Latch that requester's op and operands into the vp_* outputs.
  - Record its index as the owner and go to ISSUE.
  - If vp_busy = 1, stay in IDLE and grant nothing.
- ISSUE (exactly 1 cycle):
  - vp_start = 1 and req_ready[owner] = 1.
  - Pointer <= owner+1, wrapping to 0 after NUM_REQ-1.
  - Clear the watchdog and go to WAIT.
- WAIT:
  - If vp_result_valid = 1, latch vp_result into rsp_data, set rsp_timeout = 0, go to RESPOND.
  - Else, if the watchdog = TIMEOUT_CYCLES-1, set rsp_data = 0 and rsp_timeout = 1, saturating-increment timeout_count (max 255), go to RESPOND.
  - Otherwise increment the watchdog.
  - If vp_result_valid arrives on the final watchdog cycle, the result wins: no timeout.
- RESPOND (exactly 1 cycle):
  - rsp_valid[owner] = 1; rsp_data and rsp_timeout hold their values until the next RESPOND.
  - Next state is IDLE.
- Latency: request seen in IDLE at cycle T gives req_ready and vp_start at T+1. A result at cycle R in WAIT gives rsp_valid at R+1. Back-to-back grants are possible: the next IDLE decision occurs one cycle after RESPOND.
- The vp_* operand outputs hold their values after ISSUE until the next grant.
- Requesters must not change operands while req_valid is high and req_ready has not yet pulsed. A req_valid dropped before capture is simply not granted.
- vp_result_valid outside WAIT is ignored, with no state change.
- vp_busy is sampled only in IDLE.
- Reset asserted mid-transaction: the transaction is abandoned, with no rsp_valid. Outputs return to reset values immediately (asynchronous reset).
- Fairness: a requester that holds req_valid continuously is granted within NUM_REQ transactions.

Test Plan:
- Single request: req_valid[2]=1, op=4, scalar=0x0080, vp_busy=0 -> req_ready[2] and vp_start at T+1 with vp_scalar=0x0080. vp_result=0x7F80_0000_0000_7F80 two cycles later -> rsp_valid=4'b0100 with the same data, rsp_timeout=0.
- Round-robin: req_valid=4'b1111 held; each vector processor replies after 3 cycles -> grant order 0,1,2,3,0. Each rsp_valid bit matches its req_ready bit.
- Busy gating: vp_busy=1 for 10 cycles with req_valid[1]=1 -> no req_ready and no vp_start. vp_busy falls at cycle 10 -> req_ready[1] at cycle 11.
- Timeout: no vp_result_valid after issue -> rsp_valid[owner] exactly TIMEOUT_CYCLES+1 cycles after vp_start, with rsp_data=0, rsp_timeout=1, timeout_count=1. A result on the last watchdog cycle -> rsp_timeout=0 and timeout_count unchanged.
- Stray/reset: vp_result_valid pulsed in IDLE -> no rsp_valid. rst pulsed in WAIT -> all outputs 0 at once, no rsp_valid; the next request is granted to requester 0 first.
